// File: rtl/boot_seq_pkg.sv
// Shared types and default constants for the boot sequencer and its arbiter.
package boot_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ARM  = 2'd1,
        ST_FEN  = 2'd2,
        ST_RUN  = 2'd3
    } boot_state_e;

    localparam logic [31:0] BOOT_BASE_DEF  = 32'h0000_0080;
    localparam int          MAX_WORDS_DEF  = 32;
    localparam logic [31:0] END_MARKER_DEF = 32'h0000_0fff;

    localparam logic OWNER_SPI  = 1'b0;
    localparam logic OWNER_CORE = 1'b1;

endpackage

// File: rtl/boot_seq_arb.sv
// Fixed-priority SRAM arbiter (core over SPI) with a one-bit owner register
// that routes read data and rvalid back to the requester one cycle after grant.
module boot_seq_arb
    import boot_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_en,
    input  logic              spi_en,
    input  logic              spi_wr_ok,
    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_gnt,
    output logic              spi_rvalid,
    output logic [DATA_W-1:0] spi_rdata,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rd_pending
);

    logic owner;
    logic read_gnt;

    // SPI writes never touch the SRAM while the core owns it, so they are
    // granted alongside a core access and simply not forwarded.
    always_comb begin
        core_gnt  = core_en & core_req;
        spi_gnt   = spi_en & spi_req & (spi_we | ~core_gnt);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_req  = 1'b1;
            mem_addr = core_addr;
        end else if (spi_gnt && (!spi_we || spi_wr_ok)) begin
            mem_req   = 1'b1;
            mem_we    = spi_we;
            mem_addr  = spi_addr;
            mem_wdata = spi_we ? spi_wdata : '0;
        end
    end

    assign read_gnt = mem_req & ~mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending <= 1'b0;
            owner      <= OWNER_SPI;
        end else begin
            rd_pending <= read_gnt;
            if (read_gnt) begin
                owner <= core_gnt ? OWNER_CORE : OWNER_SPI;
            end
        end
    end

    assign spi_rvalid  = rd_pending & (owner == OWNER_SPI);
    assign core_rvalid = rd_pending & (owner == OWNER_CORE);
    assign spi_rdata   = spi_rvalid ? mem_rdata : '0;
    assign core_rdata  = core_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/boot_seq.sv
// Boot sequencer: SPI image load into the boot window, then a two-cycle core release.
// Optional end-of-image marker detection is enabled by defining BOOT_SEQ_END_MARKER_EN.
module boot_seq
    import boot_seq_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BOOT_BASE  = ADDR_W'(BOOT_BASE_DEF),
    parameter int                MAX_WORDS  = MAX_WORDS_DEF,
    parameter logic [DATA_W-1:0] END_MARKER = DATA_W'(END_MARKER_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              host_go_i,
    input  logic              boot_restart_i,
    input  logic              spi_req_i,
    input  logic              spi_we_i,
    input  logic [ADDR_W-1:0] spi_addr_i,
    input  logic [DATA_W-1:0] spi_wdata_i,
    output logic              spi_gnt_o,
    output logic              spi_rvalid_o,
    output logic [DATA_W-1:0] spi_rdata_o,
    input  logic              core_req_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              fetch_enable_o,
    output logic              en_ifetch_o,
    output logic              boot_done_o,
    output logic [5:0]        word_cnt_o,
    output logic              err_o
);

`ifdef BOOT_SEQ_END_MARKER_EN
    localparam bit MARKER_EN = 1'b1;
`else
    localparam bit MARKER_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] WIN_LO   = {1'b0, BOOT_BASE};
    localparam logic [ADDR_W:0] WIN_HI   = WIN_LO + (ADDR_W+1)'(4 * MAX_WORDS);
    localparam logic [5:0]      CNT_FULL = 6'(MAX_WORDS);

    boot_state_e state;
    logic        in_window;
    logic        rd_pending;
    logic        wr_accept;
    logic        wr_illegal;
    logic        marker_hit;
    logic        load_done;

    assign in_window = ({1'b0, spi_addr_i} >= WIN_LO) && ({1'b0, spi_addr_i} < WIN_HI);

    boot_seq_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_arb (
        .clk         (clk_i),
        .rst         (rst_i),
        .core_en     (state == ST_RUN),
        .spi_en      ((state == ST_LOAD) || (state == ST_RUN)),
        .spi_wr_ok   ((state == ST_LOAD) && in_window),
        .spi_req     (spi_req_i),
        .spi_we      (spi_we_i),
        .spi_addr    (spi_addr_i),
        .spi_wdata   (spi_wdata_i),
        .spi_gnt     (spi_gnt_o),
        .spi_rvalid  (spi_rvalid_o),
        .spi_rdata   (spi_rdata_o),
        .core_req    (core_req_i),
        .core_addr   (core_addr_i),
        .core_gnt    (core_gnt_o),
        .core_rvalid (core_rvalid_o),
        .core_rdata  (core_rdata_o),
        .mem_req     (mem_req_o),
        .mem_we      (mem_we_o),
        .mem_addr    (mem_addr_o),
        .mem_wdata   (mem_wdata_o),
        .mem_rdata   (mem_rdata_i),
        .rd_pending  (rd_pending)
    );

    // Any granted SPI write that is not a boot-window write during LOAD is dropped.
    assign wr_accept  = (state == ST_LOAD) && spi_gnt_o && spi_we_i && in_window;
    assign wr_illegal = spi_gnt_o && spi_we_i && !wr_accept;
    assign marker_hit = MARKER_EN && wr_accept && (spi_wdata_i == END_MARKER);
    assign load_done  = marker_hit || (wr_accept && ((word_cnt_o + 6'd1) == CNT_FULL)) || host_go_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_LOAD;
            fetch_enable_o <= 1'b0;
            en_ifetch_o    <= 1'b0;
            boot_done_o    <= 1'b0;
            word_cnt_o     <= '0;
            err_o          <= 1'b0;
        end else begin
            if (wr_illegal) begin
                err_o <= 1'b1;
            end
            case (state)
                ST_LOAD: begin
                    if (wr_accept) begin
                        word_cnt_o <= word_cnt_o + 6'd1;
                    end
                    if (load_done) begin
                        state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!rd_pending) begin
                        state          <= ST_FEN;
                        fetch_enable_o <= 1'b1;
                    end
                end
                ST_FEN: begin
                    state       <= ST_RUN;
                    en_ifetch_o <= 1'b1;
                    boot_done_o <= 1'b1;
                end
                ST_RUN: begin
                    if (boot_restart_i) begin
                        state          <= ST_LOAD;
                        fetch_enable_o <= 1'b0;
                        en_ifetch_o    <= 1'b0;
                        boot_done_o    <= 1'b0;
                        word_cnt_o     <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_seq.sv
// Self-checking bench for boot_seq: vector table, directed boot sequences and a
// randomized run against a behavioural model with its own copy of the SRAM.
module tb_boot_seq;

    localparam int M_LOAD = 0;
    localparam int M_ARM  = 1;
    localparam int M_FEN  = 2;
    localparam int M_RUN  = 3;

`ifdef BOOT_SEQ_END_MARKER_EN
    localparam bit MARKER_ON = 1'b1;
`else
    localparam bit MARKER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_go = 1'b0;
    logic        boot_restart = 1'b0;
    logic        spi_req = 1'b0;
    logic        spi_we = 1'b0;
    logic [31:0] spi_addr = '0;
    logic [31:0] spi_wdata = '0;
    logic        spi_gnt;
    logic        spi_rvalid;
    logic [31:0] spi_rdata;
    logic        core_req = 1'b0;
    logic [31:0] core_addr = '0;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        fetch_enable;
    logic        en_ifetch;
    logic        boot_done;
    logic [5:0]  word_cnt;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sram    [256];
    logic [31:0] ref_mem [256];

    int          m_mode;
    int          m_cnt;
    bit          m_err;
    bit          m_pend;
    bit          m_pend_core;
    logic [31:0] m_pend_data;

    logic        s_spi_gnt, s_core_gnt, s_mem_req, s_spi_rvalid, s_core_rvalid;
    logic        s_fen, s_en, s_boot, s_err;
    logic [31:0] s_spi_rdata, s_core_rdata;
    logic [5:0]  s_cnt;

    boot_seq dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host_go_i      (host_go),
        .boot_restart_i (boot_restart),
        .spi_req_i      (spi_req),
        .spi_we_i       (spi_we),
        .spi_addr_i     (spi_addr),
        .spi_wdata_i    (spi_wdata),
        .spi_gnt_o      (spi_gnt),
        .spi_rvalid_o   (spi_rvalid),
        .spi_rdata_o    (spi_rdata),
        .core_req_i     (core_req),
        .core_addr_i    (core_addr),
        .core_gnt_o     (core_gnt),
        .core_rvalid_o  (core_rvalid),
        .core_rdata_o   (core_rdata),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .fetch_enable_o (fetch_enable),
        .en_ifetch_o    (en_ifetch),
        .boot_done_o    (boot_done),
        .word_cnt_o     (word_cnt),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    // SRAM environment: reads return one cycle after the request.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) sram[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[9:2]];
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        m_mode = M_LOAD;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_pend = 1'b0;
        m_pend_core = 1'b0;
        m_pend_data = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " spi_gnt"},      32'(spi_gnt), 0);
        checkOutput({tag, " spi_rvalid"},   32'(spi_rvalid), 0);
        checkOutput({tag, " spi_rdata"},    spi_rdata, 0);
        checkOutput({tag, " core_gnt"},     32'(core_gnt), 0);
        checkOutput({tag, " core_rvalid"},  32'(core_rvalid), 0);
        checkOutput({tag, " core_rdata"},   core_rdata, 0);
        checkOutput({tag, " mem_req"},      32'(mem_req), 0);
        checkOutput({tag, " mem_we"},       32'(mem_we), 0);
        checkOutput({tag, " mem_addr"},     mem_addr, 0);
        checkOutput({tag, " mem_wdata"},    mem_wdata, 0);
        checkOutput({tag, " fetch_enable"}, 32'(fetch_enable), 0);
        checkOutput({tag, " en_ifetch"},    32'(en_ifetch), 0);
        checkOutput({tag, " boot_done"},    32'(boot_done), 0);
        checkOutput({tag, " word_cnt"},     32'(word_cnt), 0);
        checkOutput({tag, " err"},          32'(err), 0);
    endtask

    // One clock cycle: drive at the falling edge, compare against the model,
    // then advance the model to what the next rising edge should produce.
    task automatic applyStimulus(input logic sreq, input logic swe, input logic [31:0] saddr,
                                 input logic [31:0] swdata, input logic creq, input logic [31:0] caddr,
                                 input logic hgo, input logic rstrt);
        logic        in_win, e_cg, e_sg, e_req, e_we, acc;
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        spi_req = sreq; spi_we = swe; spi_addr = saddr; spi_wdata = swdata;
        core_req = creq; core_addr = caddr; host_go = hgo; boot_restart = rstrt;
        #1;
        in_win = (saddr >= 32'h80) && (saddr < 32'h80 + 4 * 32);
        e_cg = (m_mode == M_RUN) && creq;
        e_sg = sreq && ((m_mode == M_LOAD) || ((m_mode == M_RUN) && (swe || !creq)));
        e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (e_cg) begin
            e_req = 1'b1; e_addr = caddr;
        end else if (e_sg && (!swe || (m_mode == M_LOAD && in_win))) begin
            e_req = 1'b1; e_we = swe; e_addr = saddr; e_wd = swe ? swdata : '0;
        end
        checkOutput("spi_gnt",      32'(spi_gnt), 32'(e_sg));
        checkOutput("core_gnt",     32'(core_gnt), 32'(e_cg));
        checkOutput("mem_req",      32'(mem_req), 32'(e_req));
        checkOutput("mem_we",       32'(mem_we), 32'(e_we));
        checkOutput("mem_addr",     mem_addr, e_addr);
        checkOutput("mem_wdata",    mem_wdata, e_wd);
        checkOutput("spi_rvalid",   32'(spi_rvalid), 32'(m_pend && !m_pend_core));
        checkOutput("spi_rdata",    spi_rdata, (m_pend && !m_pend_core) ? m_pend_data : 32'h0);
        checkOutput("core_rvalid",  32'(core_rvalid), 32'(m_pend && m_pend_core));
        checkOutput("core_rdata",   core_rdata, (m_pend && m_pend_core) ? m_pend_data : 32'h0);
        checkOutput("fetch_enable", 32'(fetch_enable), 32'(m_mode == M_FEN || m_mode == M_RUN));
        checkOutput("en_ifetch",    32'(en_ifetch), 32'(m_mode == M_RUN));
        checkOutput("boot_done",    32'(boot_done), 32'(m_mode == M_RUN));
        checkOutput("word_cnt",     32'(word_cnt), 32'(m_cnt));
        checkOutput("err",          32'(err), 32'(m_err));
        s_spi_gnt = spi_gnt; s_core_gnt = core_gnt; s_mem_req = mem_req;
        s_spi_rvalid = spi_rvalid; s_core_rvalid = core_rvalid;
        s_spi_rdata = spi_rdata; s_core_rdata = core_rdata;
        s_fen = fetch_enable; s_en = en_ifetch; s_boot = boot_done; s_err = err; s_cnt = word_cnt;

        if (e_req && e_we) ref_mem[e_addr[9:2]] = swdata;
        case (m_mode)
            M_LOAD: begin
                acc = sreq && swe && in_win;
                if (sreq && swe && !in_win) m_err = 1'b1;
                if (acc) m_cnt++;
                if ((acc && MARKER_ON && swdata == 32'h0000_0fff) || (acc && m_cnt == 32) || hgo)
                    m_mode = M_ARM;
            end
            M_ARM: if (!m_pend) m_mode = M_FEN;
            M_FEN: m_mode = M_RUN;
            default: begin
                if (e_sg && swe) m_err = 1'b1;
                if (rstrt) begin
                    m_mode = M_LOAD;
                    m_cnt  = 0;
                end
            end
        endcase
        m_pend      = e_req && !e_we;
        m_pend_core = e_cg;
        m_pend_data = ref_mem[e_addr[9:2]];
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
        core_req = 0; core_addr = 0; host_go = 0; boot_restart = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resetModel();
    endtask

    typedef struct {
        logic        spi_req;
        logic        spi_we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        core_req;
        logic        e_spi_gnt;
        logic        e_core_gnt;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [5:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int fen_at, en_at;
        logic [31:0] core_word;

        for (int i = 0; i < 256; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        resetModel();

        repeat (2) @(posedge clk);
        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        // LOAD-phase vectors: in-window, out-of-window and boundary addresses.
        vecs[0] = '{1, 1, 32'h80,  32'h1111_0000, 0, 1, 0, 1, 1, 6'd1, 0};
        vecs[1] = '{1, 1, 32'h84,  32'h1111_0001, 0, 1, 0, 1, 1, 6'd2, 0};
        vecs[2] = '{1, 0, 32'h84,  32'h0,         1, 1, 0, 1, 0, 6'd2, 0};
        vecs[3] = '{1, 1, 32'h40,  32'hdead_beef, 0, 1, 0, 0, 0, 6'd2, 1};
        vecs[4] = '{1, 1, 32'h100, 32'hdead_beef, 0, 1, 0, 0, 0, 6'd2, 1};
        vecs[5] = '{1, 1, 32'hfc,  32'h1111_00fc, 0, 1, 0, 1, 1, 6'd3, 1};
        vecs[6] = '{1, 0, 32'h40,  32'h0,         0, 1, 0, 1, 0, 6'd3, 1};
        vecs[7] = '{0, 0, 32'h0,   32'h0,         1, 0, 0, 0, 0, 6'd3, 1};
        vecs[8] = '{1, 1, 32'h7c,  32'h2222_0000, 0, 1, 0, 0, 0, 6'd3, 1};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].spi_req, vecs[i].spi_we, vecs[i].addr, vecs[i].wdata,
                          vecs[i].core_req, 32'h200, 0, 0);
            checkOutput($sformatf("vec%0d spi_gnt", i),  32'(s_spi_gnt),  32'(vecs[i].e_spi_gnt));
            checkOutput($sformatf("vec%0d core_gnt", i), 32'(s_core_gnt), 32'(vecs[i].e_core_gnt));
            checkOutput($sformatf("vec%0d mem_req", i),  32'(s_mem_req),  32'(vecs[i].e_mem_req));
            checkOutput($sformatf("vec%0d mem_we", i),   32'(mem_we),     32'(vecs[i].e_mem_we));
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d word_cnt", i), 32'(word_cnt),   32'(vecs[i].e_cnt));
            checkOutput($sformatf("vec%0d err", i),      32'(err),        32'(vecs[i].e_err));
        end

        // Boot image load and the two-cycle release.
        doReset();
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 1, 32'h80 + 32'(4 * k), 32'ha000_0000 + 32'(k), 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h90, 32'h0000_0fff, 0, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("load five words word_cnt", 32'(word_cnt), 5);
        if (!MARKER_ON) begin
            for (int k = 5; k < 32; k++)
                applyStimulus(1, 1, 32'h80 + 32'(4 * k), 32'ha000_0000 + 32'(k), 0, 0, 0, 0);
        end
        fen_at = -1;
        en_at  = -1;
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (fen_at < 0 && s_fen) fen_at = k;
            if (en_at < 0 && s_en) en_at = k;
        end
        checkOutput("release fetch_enable cycle", 32'(fen_at), 2);
        checkOutput("release en_ifetch cycle", 32'(en_at), 3);
        checkOutput("release boot_done", 32'(s_boot), 1);
        checkOutput("release word_cnt", 32'(s_cnt), MARKER_ON ? 32'd5 : 32'd32);

        // RUN arbitration: core wins a collision, SPI goes next idle cycle.
        core_word = ref_mem[64];
        applyStimulus(1, 0, 32'h84, 0, 1, 32'h100, 0, 0);
        checkOutput("run collide core_gnt", 32'(s_core_gnt), 1);
        checkOutput("run collide spi_gnt", 32'(s_spi_gnt), 0);
        applyStimulus(1, 0, 32'h84, 0, 0, 0, 0, 0);
        checkOutput("run spi_gnt", 32'(s_spi_gnt), 1);
        checkOutput("run core_rvalid", 32'(s_core_rvalid), 1);
        checkOutput("run core_rdata", s_core_rdata, core_word);
        applyStimulus(1, 1, 32'h88, 32'h1234_5678, 0, 0, 0, 0);
        checkOutput("run spi_rvalid", 32'(s_spi_rvalid), 1);
        checkOutput("run spi_rdata", s_spi_rdata, 32'ha000_0001);
        checkOutput("run spi write granted", 32'(s_spi_gnt), 1);
        checkOutput("run spi write dropped", 32'(s_mem_req), 0);
        idle();
        checkOutput("run spi write err", 32'(s_err), 1);

        // Restart back to LOAD keeps the error flag.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        checkOutput("restart fetch_enable", 32'(s_fen), 0);
        checkOutput("restart en_ifetch", 32'(s_en), 0);
        checkOutput("restart boot_done", 32'(s_boot), 0);
        checkOutput("restart word_cnt", 32'(s_cnt), 0);
        checkOutput("restart err kept", 32'(s_err), 1);

        // host_go with a read in flight: ARM must wait for the return.
        applyStimulus(1, 0, 32'h80, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 32'h84, 0, 0, 0, 0, 0);
        checkOutput("arm no spi_gnt", 32'(s_spi_gnt), 0);
        checkOutput("arm spi_rvalid", 32'(s_spi_rvalid), 1);
        checkOutput("arm spi_rdata", s_spi_rdata, 32'ha000_0000);
        checkOutput("arm hold fetch_enable", 32'(s_fen), 0);
        idle();
        checkOutput("arm drain fetch_enable", 32'(s_fen), 0);
        idle();
        checkOutput("fen fetch_enable", 32'(s_fen), 1);
        checkOutput("fen en_ifetch", 32'(s_en), 0);
        idle();
        checkOutput("run en_ifetch", 32'(s_en), 1);

        // Asynchronous reset with a read outstanding.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 32'h88, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
        core_req = 0; core_addr = 0; host_go = 0; boot_restart = 0;
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        @(negedge clk);
        rst = 1'b0;
        resetModel();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            logic        sreq, swe, creq, hgo, rstrt;
            logic [31:0] saddr, swdata, caddr;
            sreq   = 1'($urandom_range(0, 1));
            swe    = ($urandom_range(0, 2) != 0);
            saddr  = ($urandom_range(0, 3) != 0) ? 32'h80 + 32'(4 * $urandom_range(0, 31))
                                                 : 32'(4 * $urandom_range(0, 255));
            swdata = ($urandom_range(0, 7) == 0) ? 32'h0000_0fff : $urandom;
            creq   = 1'($urandom_range(0, 1));
            caddr  = 32'(4 * $urandom_range(0, 255));
            hgo    = ($urandom_range(0, 39) == 0);
            rstrt  = ($urandom_range(0, 29) == 0);
            applyStimulus(sreq, swe, saddr, swdata, creq, caddr, hgo, rstrt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_seq.md
# boot_seq

Boot sequencer and memory-port arbiter for `top_core`. It shares the single-port instruction/data SRAM between the SPI-device loader and the core fetch port. During load, it accepts SPI writes into the boot window and detects end of image. It then raises `fetch_enable` and `en_ifetch` in a fixed two-cycle release sequence, so the core no longer depends on externally driven enables.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `BOOT_BASE`, 32'h80, first byte address of the boot window
- `MAX_WORDS`, 32, boot window size in words
- `END_MARKER`, 32'h00000fff, data word that terminates the image
- `clk_i`  in  1  single clock
- `rst_i`  in  1  asynchronous reset, active-high
- `host_go_i`  in  1  one-cycle pulse; forces LOAD→ARM
- `boot_restart_i`  in  1  one-cycle pulse; RUN→LOAD
- `spi_req_i`, `spi_we_i`  in  1  SPI-side request, write strobe
- `spi_addr_i`  in  ADDR_W  SPI byte address
- `spi_wdata_i`  in  DATA_W  SPI write data
- `spi_gnt_o`, `spi_rvalid_o`  out  1  grant, read-data valid
- `spi_rdata_o`  out  DATA_W  read data
- `core_req_i`  in  1  core fetch request (read only)
- `core_addr_i`  in  ADDR_W  fetch byte address
- `core_gnt_o`, `core_rvalid_o`  out  1  grant, read-data valid
- `core_rdata_o`  out  DATA_W  fetch data
- `mem_req_o`, `mem_we_o`  out  1  SRAM request, write enable
- `mem_addr_o`  out  ADDR_W  SRAM byte address
- `mem_wdata_o`  out  DATA_W  SRAM write data
- `mem_rdata_i`  in  DATA_W  SRAM read data, valid 1 cycle after read grant
- `fetch_enable_o`, `en_ifetch_o`  out  1  core enables
- `boot_done_o`  out  1  high in RUN
- `word_cnt_o`  out  6  accepted boot-window writes
- `err_o`  out  1  sticky illegal-access flag

## Operation
- States: LOAD, ARM, FEN, RUN.
- **LOAD:**
  - SPI owns the SRAM; `core_gnt_o`=0.
  - SPI read: granted and forwarded.
  - SPI write inside [BOOT_BASE, BOOT_BASE+4*MAX_WORDS): granted, forwarded, `word_cnt_o`++.
  - SPI write outside the window: granted but not forwarded (`mem_req_o`=0); `err_o` set.
  - Exit to ARM on: an accepted write with data==END_MARKER (marker is still written), OR `word_cnt_o` reaching MAX_WORDS, OR `host_go_i`.
- **ARM:**
  - No grants.
  - Waits until no read is outstanding, then →FEN.
- **FEN:** `fetch_enable_o`=1; →RUN next cycle.
- **RUN:**
  - `fetch_enable_o`=`en_ifetch_o`=`boot_done_o`=1.
  - Fixed priority: core first, then SPI.
  - SPI reads are granted only when `core_req_i`=0.
  - SPI writes are granted but dropped; `err_o` set.
  - `boot_restart_i` →LOAD: enables drop the same edge, `word_cnt_o` clears, `err_o` is kept.
- Read return: a 1-bit owner register, captured at grant, steers `mem_rdata_i` and `*_rvalid_o` on the following cycle. Writes produce no rvalid.
- Reads of an address outside the window are legal.
- Simultaneous events:
  - `host_go_i` together with an accepted write: the write completes and the state enters ARM.
  - `boot_restart_i` outside RUN: ignored.
- `err_o` clears only on reset.

## Timing
- Grant is combinational from request in the same cycle; `mem_*` outputs are combinational from the grant.
- Read data returns exactly 1 cycle after grant.
- Marker-write cycle N: ARM at N+1; FEN at N+2 if nothing is outstanding; RUN (`en_ifetch_o`=1) at N+3.
- `fetch_enable_o` rises exactly one cycle before `en_ifetch_o`.
- Reset values:
  - State LOAD; all `*_gnt_o`, `*_rvalid_o`, `mem_req_o`, `mem_we_o`, enables, `boot_done_o`, `err_o` = 0.
  - `word_cnt_o`=0; data/address outputs = 0.
- Reset mid-load or mid-run returns to LOAD immediately (asynchronous); an outstanding read's rvalid is discarded.

## Configuration
- Macro: `BOOT_SEQ_END_MARKER_EN`.
  - Defined: END_MARKER detection is active as described above.
  - Undefined: marker data is an ordinary word; LOAD exits only on a full window or `host_go_i`.

## Structure
- `boot_seq_pkg` holds:
  - State enum `boot_state_e`.
  - Default constants `BOOT_BASE_DEF`, `MAX_WORDS_DEF`, `END_MARKER_DEF`.
  - Owner encoding `OWNER_SPI` / `OWNER_CORE`.
- Sub-module `boot_seq_arb` contains the two-requester fixed-priority arbiter, the owner register, and rvalid steering. It has a `core_en` input driven by the FSM.

## Test plan
- Write 4 words to 0x80..0x8c, then 0x00000fff to 0x90 → `word_cnt_o`=5, ARM next cycle, `fetch_enable_o` one cycle before `en_ifetch_o`, `boot_done_o`=1.
- Write 32 words to 0x80..0xfc without the marker → RUN entered after the 32nd write; with the macro undefined, a marker at word 3 is ignored and the same result holds.
- SPI write to 0x40 in LOAD → no `mem_req_o`, `err_o`=1, `word_cnt_o` unchanged.
- In RUN, `core_req_i` and an SPI read to 0x84 in the same cycle → core granted; SPI granted the next idle cycle; each rvalid arrives 1 cycle after its grant with the correct data.
- `host_go_i` pulse in LOAD with an SPI read outstanding → ARM holds until the read returns, then FEN→RUN.
- `boot_restart_i` in RUN → enables 0, LOAD, `word_cnt_o`=0, `err_o` retained; `rst_i` mid-LOAD → all outputs 0.
